// File: rtl/cache_to_hbm_bridge_pkg.sv
// cache_to_hbm_bridge_pkg: DMA packet layout and bridge FSM states
package cache_to_hbm_bridge_pkg;
  localparam int dma_addr_width_lp = 27;
  typedef struct packed {
    logic                         write_not_read;
    logic [dma_addr_width_lp-1:0] addr;
  } dma_pkt_s;
  typedef enum logic [2:0] {IDLE, WR_COLLECT, WR_REQ, WR_DATA, RD_REQ, RD_WAIT, RD_RETURN} state_e;
endpackage

// File: rtl/cache_to_hbm_bridge_if.sv
// cache_to_hbm_bridge_if: cache DMA ports and HBM channel port seen by the bridge
interface cache_to_hbm_bridge_if
  import cache_to_hbm_bridge_pkg::*;
#(
  parameter int num_cache_p              = 1,
  parameter int addr_width_p             = dma_addr_width_lp,
  parameter int data_width_p             = 32,
  parameter int hbm_channel_addr_width_p = 28,
  parameter int hbm_data_width_p         = 256
);
  logic [num_cache_p*(addr_width_p+1)-1:0] dma_pkt;
  logic [num_cache_p-1:0]                  dma_pkt_v, dma_pkt_yumi;
  logic [num_cache_p*data_width_p-1:0]     dma_fill_data, dma_wb_data;
  logic [num_cache_p-1:0]                  dma_fill_v, dma_fill_ready;
  logic [num_cache_p-1:0]                  dma_wb_v, dma_wb_yumi;
  logic                                    hbm_req_v, hbm_write_not_read, hbm_req_yumi;
  logic [hbm_channel_addr_width_p-1:0]     hbm_ch_addr;
  logic                                    hbm_wdata_v, hbm_wdata_yumi, hbm_rdata_v;
  logic [hbm_data_width_p-1:0]             hbm_wdata, hbm_rdata;
  modport master (
    input  dma_pkt, dma_pkt_v, dma_fill_ready, dma_wb_data, dma_wb_v,
           hbm_req_yumi, hbm_wdata_yumi, hbm_rdata_v, hbm_rdata,
    output dma_pkt_yumi, dma_fill_data, dma_fill_v, dma_wb_yumi,
           hbm_req_v, hbm_write_not_read, hbm_ch_addr, hbm_wdata_v, hbm_wdata
  );
  modport slave (
    output dma_pkt, dma_pkt_v, dma_fill_ready, dma_wb_data, dma_wb_v,
           hbm_req_yumi, hbm_wdata_yumi, hbm_rdata_v, hbm_rdata,
    input  dma_pkt_yumi, dma_fill_data, dma_fill_v, dma_wb_yumi,
           hbm_req_v, hbm_write_not_read, hbm_ch_addr, hbm_wdata_v, hbm_wdata
  );
endinterface

// File: rtl/cache_to_hbm_bridge_rr_arb.sv
// cache_to_hbm_rr_arb: round-robin arbiter, pointer moves past the winner on adv
module cache_to_hbm_rr_arb #(
  parameter  int num_p = 1,
  localparam int id_lp = num_p > 1 ? $clog2(num_p) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [num_p-1:0] req,
  input  logic             adv,
  output logic [num_p-1:0] grant,
  output logic [id_lp-1:0] id,
  output logic             v
);
  logic [id_lp-1:0] ptr_r;
  always_comb begin
    int j;
    j = 0;
    id = '0;
    v = 1'b0;
    for (int i = 0; i < num_p; i++) begin
      j = (int'(ptr_r) + i) % num_p;
      if (!v && req[j]) begin
        v = 1'b1;
        id = id_lp'(j);
      end
    end
    grant = v ? num_p'(1) << id : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ptr_r <= '0;
    else if (adv) ptr_r <= int'(id) == num_p - 1 ? '0 : id + 1'b1;
endmodule

// File: rtl/cache_to_hbm_bridge.sv
// cache_to_hbm_bridge: turns each cache DMA packet into one full-block HBM channel
// read or write, packing words into beats; one transaction in flight.
module cache_to_hbm_bridge
  import cache_to_hbm_bridge_pkg::*;
#(
  parameter int num_cache_p              = 1,
  parameter int addr_width_p             = dma_addr_width_lp,
  parameter int data_width_p             = 32,
  parameter int block_size_in_words_p    = 8,
  parameter int cache_bank_addr_width_p  = 27,
  parameter int hbm_channel_addr_width_p = 28,
  parameter int hbm_data_width_p         = 256
) (
  input logic                   clk,
  input logic                   reset_n,
  cache_to_hbm_bridge_if.master bus
);
  localparam int w_lp     = block_size_in_words_p;
  localparam int block_lp = w_lp * data_width_p;
  localparam int n_lp     = block_lp / hbm_data_width_p;
  localparam int id_lp    = num_cache_p > 1 ? $clog2(num_cache_p) : 1;
  localparam int cnt_lp   = $clog2(w_lp + 1);

  state_e                  state_r, state_n;
  logic [cnt_lp-1:0]       cnt_r, cnt_n;
  logic [id_lp-1:0]        id_r, arb_id;
  logic [num_cache_p-1:0]  grant, sel_oh;
  dma_pkt_s                pkt_r, sel_pkt;
  logic [block_lp-1:0]     block_r;
  logic [data_width_p-1:0] wb_word;
  logic arb_v, take, wb_fire, rd_fire, fill_fire, last_word, last_beat;

  cache_to_hbm_rr_arb #(.num_p(num_cache_p)) arb (
    .clk(clk), .reset_n(reset_n), .req(bus.dma_pkt_v), .adv(take),
    .grant(grant), .id(arb_id), .v(arb_v)
  );

  // gating with reset_n keeps yumi low while reset is held, even with valid packets
  assign take      = reset_n && state_r == IDLE && arb_v;
  assign sel_oh    = num_cache_p'(1) << id_r;
  assign sel_pkt   = bus.dma_pkt[int'(arb_id)*(addr_width_p+1) +: addr_width_p+1];
  assign wb_word   = bus.dma_wb_data[int'(id_r)*data_width_p +: data_width_p];
  assign wb_fire   = state_r == WR_COLLECT && bus.dma_wb_v[id_r];
  assign rd_fire   = state_r == RD_WAIT && bus.hbm_rdata_v;
  assign fill_fire = state_r == RD_RETURN && bus.dma_fill_ready[id_r];
  assign last_word = cnt_r == cnt_lp'(w_lp - 1);
  assign last_beat = cnt_r == cnt_lp'(n_lp - 1);

  assign bus.dma_pkt_yumi       = take ? grant : '0;
  assign bus.dma_wb_yumi        = wb_fire ? sel_oh : '0;
  assign bus.dma_fill_v         = state_r == RD_RETURN ? sel_oh : '0;
  assign bus.dma_fill_data      = {num_cache_p{block_r[int'(cnt_r)*data_width_p +: data_width_p]}};
  assign bus.hbm_req_v          = state_r == WR_REQ || state_r == RD_REQ;
  assign bus.hbm_write_not_read = pkt_r.write_not_read;
  assign bus.hbm_ch_addr        = hbm_channel_addr_width_p'(pkt_r.addr[cache_bank_addr_width_p-1:0])
                                | (hbm_channel_addr_width_p'(id_r) << cache_bank_addr_width_p);
  assign bus.hbm_wdata_v        = state_r == WR_DATA;
  assign bus.hbm_wdata          = block_r[int'(cnt_r)*hbm_data_width_p +: hbm_data_width_p];

  always_comb begin
    state_n = state_r;
    cnt_n = cnt_r;
    case (state_r)
      IDLE: if (take) begin
        state_n = sel_pkt.write_not_read ? WR_COLLECT : RD_REQ;
        cnt_n = '0;
      end
      WR_COLLECT: if (wb_fire) begin
        state_n = last_word ? WR_REQ : WR_COLLECT;
        cnt_n = last_word ? '0 : cnt_r + 1'b1;
      end
      WR_REQ: state_n = bus.hbm_req_yumi ? WR_DATA : WR_REQ;
      WR_DATA: if (bus.hbm_wdata_yumi) begin
        state_n = last_beat ? IDLE : WR_DATA;
        cnt_n = last_beat ? '0 : cnt_r + 1'b1;
      end
      RD_REQ: state_n = bus.hbm_req_yumi ? RD_WAIT : RD_REQ;
      RD_WAIT: if (rd_fire) begin
        state_n = last_beat ? RD_RETURN : RD_WAIT;
        cnt_n = last_beat ? '0 : cnt_r + 1'b1;
      end
      RD_RETURN: if (fill_fire) begin
        state_n = last_word ? IDLE : RD_RETURN;
        cnt_n = last_word ? '0 : cnt_r + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r <= '0;
      id_r <= '0;
      pkt_r <= '0;
    end else begin
      state_r <= state_n;
      cnt_r <= cnt_n;
      if (take) begin
        id_r <= arb_id;
        pkt_r <= sel_pkt;
      end
    end

  always_ff @(posedge clk) begin
    if (wb_fire) block_r[int'(cnt_r)*data_width_p +: data_width_p] <= wb_word;
    if (rd_fire) block_r[int'(cnt_r)*hbm_data_width_p +: hbm_data_width_p] <= bus.hbm_rdata;
  end
endmodule

// File: tb/tb_cache_to_hbm_bridge.sv
// tb_cache_to_hbm_bridge: directed checks of a 2-cache bridge with 128-bit beats (2 beats per block)
module tb_cache_to_hbm_bridge;
  logic clk, reset_n;
  int checks = 0, failures = 0;
  int k;

  cache_to_hbm_bridge_if #(.num_cache_p(2), .addr_width_p(27), .data_width_p(32),
                           .hbm_channel_addr_width_p(28), .hbm_data_width_p(128)) bus ();

  cache_to_hbm_bridge #(.num_cache_p(2), .addr_width_p(27), .data_width_p(32),
                        .block_size_in_words_p(8), .cache_bank_addr_width_p(27),
                        .hbm_channel_addr_width_p(28), .hbm_data_width_p(128)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_read(input logic [1:0] g, input logic [27:0] a, input logic [255:0] blk);
    #1;
    chk("rd_grant", bus.dma_pkt_yumi, g);
    tick;
    chk("rd_req_v", bus.hbm_req_v, 1);
    chk("rd_wnr", bus.hbm_write_not_read, 0);
    chk("rd_addr", bus.hbm_ch_addr, a);
    bus.hbm_req_yumi = 1'b1;
    tick;
    bus.hbm_req_yumi = 1'b0;
    bus.hbm_rdata_v = 1'b1;
    bus.hbm_rdata = blk[127:0];
    tick;
    bus.hbm_rdata = blk[255:128];
    tick;
    bus.hbm_rdata_v = 1'b0;
    bus.dma_fill_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rd_fill_v", bus.dma_fill_v, g);
      chk("rd_fill_word", bus.dma_fill_data[(g[1] ? 32 : 0) +: 32], blk[i*32 +: 32]);
      tick;
    end
    bus.dma_fill_ready = 2'b00;
  endtask

  task automatic run_write(input logic [1:0] g, input logic [27:0] a, input logic [31:0] b);
    #1;
    chk("wr_grant", bus.dma_pkt_yumi, g);
    tick;
    bus.dma_pkt_v = 2'b00;
    bus.dma_wb_v = g;
    for (int i = 0; i < 8; i++) begin
      bus.dma_wb_data = {2{b + 32'(i)}};
      #1;
      chk("wr_wb_yumi", bus.dma_wb_yumi, g);
      tick;
    end
    bus.dma_wb_v = 2'b00;
    #1;
    chk("wr_req_v", bus.hbm_req_v, 1);
    chk("wr_wnr", bus.hbm_write_not_read, 1);
    chk("wr_addr", bus.hbm_ch_addr, a);
    chk("wr_no_beat_yet", bus.hbm_wdata_v, 0);
    bus.hbm_req_yumi = 1'b1;
    tick;
    bus.hbm_req_yumi = 1'b0;
    #1;
    chk("wr_beat_v", bus.hbm_wdata_v, 1);
    chk("wr_beat0", bus.hbm_wdata, {b + 32'd3, b + 32'd2, b + 32'd1, b});
    tick;
    chk("wr_beat0_hold", bus.hbm_wdata, {b + 32'd3, b + 32'd2, b + 32'd1, b});
    bus.hbm_wdata_yumi = 1'b1;
    tick;
    chk("wr_beat1", bus.hbm_wdata, {b + 32'd7, b + 32'd6, b + 32'd5, b + 32'd4});
    tick;
    bus.hbm_wdata_yumi = 1'b0;
    #1;
    chk("wr_done", bus.hbm_wdata_v, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.dma_pkt = '0;
    bus.dma_pkt_v = 2'b11;
    bus.dma_fill_ready = 2'b00;
    bus.dma_wb_data = '0;
    bus.dma_wb_v = 2'b00;
    bus.hbm_req_yumi = 1'b0;
    bus.hbm_wdata_yumi = 1'b0;
    bus.hbm_rdata_v = 1'b0;
    bus.hbm_rdata = '0;
    tick;
    tick;
    chk("rst_pkt_yumi", bus.dma_pkt_yumi, 0);
    chk("rst_req_v", bus.hbm_req_v, 0);
    chk("rst_fill_v", bus.dma_fill_v, 0);
    chk("rst_wb_yumi", bus.dma_wb_yumi, 0);
    chk("rst_wdata_v", bus.hbm_wdata_v, 0);
    reset_n = 1'b1;

    // read from cache 0 with a stalled request and a stalled return
    bus.dma_pkt = {28'h0, 1'b0, 27'h40};
    bus.dma_pkt_v = 2'b01;
    #1;
    chk("rd0_grant", bus.dma_pkt_yumi, 2'b01);
    tick;
    bus.dma_pkt_v = 2'b00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rd0_req_stall_v", bus.hbm_req_v, 1);
      chk("rd0_req_stall_addr", bus.hbm_ch_addr, 28'h40);
      tick;
    end
    chk("rd0_wnr", bus.hbm_write_not_read, 0);
    bus.hbm_req_yumi = 1'b1;
    tick;
    bus.hbm_req_yumi = 1'b0;
    #1;
    chk("rd0_req_dropped", bus.hbm_req_v, 0);
    bus.hbm_rdata_v = 1'b1;
    bus.hbm_rdata = 128'h00000004_00000003_00000002_00000001;
    tick;
    bus.hbm_rdata = 128'h00000008_00000007_00000006_00000005;
    tick;
    bus.hbm_rdata_v = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 8; c++) begin
      bus.dma_fill_ready = (c >= 3 && c < 6) ? 2'b00 : 2'b01;
      #1;
      chk("rd0_fill_v", bus.dma_fill_v, 2'b01);
      chk("rd0_word", bus.dma_fill_data[31:0], 32'(k + 1));
      if (bus.dma_fill_ready[0]) k++;
      tick;
    end
    bus.dma_fill_ready = 2'b00;
    chk("rd0_word_count", k, 8);
    chk("rd0_idle", bus.dma_fill_v, 0);

    // write from cache 1; pointer now favours cache 1, id bit lands at bit 27
    bus.dma_pkt = {1'b1, 27'h100, 28'h0};
    bus.dma_pkt_v = 2'b10;
    run_write(2'b10, 28'h8000100, 32'hA0);

    // both caches request reads continuously: grants alternate
    bus.dma_pkt = {1'b0, 27'h300, 1'b0, 27'h200};
    bus.dma_pkt_v = 2'b11;
    run_read(2'b01, 28'h0000200, {32'h17, 32'h16, 32'h15, 32'h14, 32'h13, 32'h12, 32'h11, 32'h10});
    run_read(2'b10, 28'h8000300, {32'h27, 32'h26, 32'h25, 32'h24, 32'h23, 32'h22, 32'h21, 32'h20});
    run_read(2'b01, 28'h0000200, {32'h37, 32'h36, 32'h35, 32'h34, 32'h33, 32'h32, 32'h31, 32'h30});
    run_read(2'b10, 28'h8000300, {32'h47, 32'h46, 32'h45, 32'h44, 32'h43, 32'h42, 32'h41, 32'h40});

    // reset during RD_WAIT after one beat; pointer left at cache 1 before reset
    bus.dma_pkt = {28'h0, 1'b0, 27'h40};
    bus.dma_pkt_v = 2'b01;
    #1;
    chk("rst_rd_grant", bus.dma_pkt_yumi, 2'b01);
    tick;
    bus.dma_pkt_v = 2'b00;
    bus.hbm_req_yumi = 1'b1;
    tick;
    bus.hbm_req_yumi = 1'b0;
    bus.hbm_rdata_v = 1'b1;
    bus.hbm_rdata = 128'hDEAD;
    tick;
    bus.hbm_rdata_v = 1'b0;
    bus.dma_pkt_v = 2'b11;
    reset_n = 1'b0;
    #1;
    chk("midrst_req_v", bus.hbm_req_v, 0);
    chk("midrst_fill_v", bus.dma_fill_v, 0);
    chk("midrst_pkt_yumi", bus.dma_pkt_yumi, 0);
    chk("midrst_wb_yumi", bus.dma_wb_yumi, 0);
    chk("midrst_wdata_v", bus.hbm_wdata_v, 0);
    tick;
    reset_n = 1'b1;
    bus.dma_pkt = {1'b0, 27'h380, 1'b0, 27'h80};
    run_read(2'b01, 28'h0000080, {32'h57, 32'h56, 32'h55, 32'h54, 32'h53, 32'h52, 32'h51, 32'h50});

    // back-to-back write then read on cache 0
    bus.dma_pkt = {28'h0, 1'b1, 27'h1C0};
    bus.dma_pkt_v = 2'b01;
    run_write(2'b01, 28'h00001C0, 32'hB0);
    bus.dma_pkt = {28'h0, 1'b0, 27'h1C0};
    bus.dma_pkt_v = 2'b01;
    run_read(2'b01, 28'h00001C0, {32'hC7, 32'hC6, 32'hC5, 32'hC4, 32'hC3, 32'hC2, 32'hC1, 32'hC0});
    bus.dma_pkt_v = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
